wave_rom_scheduler: RTL and testbench

Time-multiplexes one synchronous waveform ROM (sine, triangle, square or saw memory) among the note voices of the note decoder. It replaces the free-running per-ROM index counters.
- Voices post read requests with addresses from their wave counters.
- A round-robin arbiter issues one ROM read per cycle.
- The block tracks ROM read latency and steers each returned sample into that voice's holding register.
One instance sits in front of each waveform ROM; its sample bus feeds the combiner.

---
 rtl/wave_rom_scheduler.sv | 137 +++++++++++++
 tb/tb_wave_rom_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_rom_scheduler.sv
// rtl/wave_rom_scheduler.sv - round-robin scheduler sharing one synchronous waveform ROM among note voices
module wave_rom_scheduler #(
  parameter int VOICES  = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [VOICES-1:0]        enables,
  input  logic [VOICES-1:0]        req,
  input  logic [VOICES*ADDR_W-1:0] req_addrs,
  output logic [VOICES-1:0]        ack,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [VOICES*DATA_W-1:0] samples,
  output logic [VOICES-1:0]        sample_valid,
  output logic                     busy
);

  localparam int ID_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  // Round-robin pointer: first voice searched in the current cycle
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_ptr;
  logic [VOICES-1:0] eligible;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ADDR_W-1:0] grant_addr;
  int                scan_idx;

  // Voice id riding along with the read currently presented on rom_en
  logic [ID_W-1:0]   cur_id;

  // Latency pipeline: (valid, id) for every read still inside the ROM
  logic [ROM_LAT-1:0] pipe_valid;
  logic [ID_W-1:0]    pipe_id [ROM_LAT];
  logic               ret_valid;
  logic [ID_W-1:0]    ret_id;

  // A voice that is being acked this cycle is masked so a slow req drop cannot earn a second grant
  always_comb begin
    eligible = req & enables & ~ack;
  end

  // Rotating priority search starting at rr_ptr, first eligible voice wins
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_addr  = '0;
    scan_idx    = 0;
    for (int j = 0; j < VOICES; j++) begin
      scan_idx = int'(rr_ptr) + j;
      if (scan_idx >= VOICES) begin
        scan_idx = scan_idx - VOICES;
      end
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(scan_idx);
        grant_addr  = req_addrs[scan_idx*ADDR_W +: ADDR_W];
      end
    end
  end

  // Priority moves to the voice after the winner, wrapping at VOICES
  always_comb begin
    if (grant_id == ID_W'(VOICES - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id + ID_W'(1);
    end
  end

  // Registered grant: ack pulse, ROM read strobe and address; address holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      cur_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      ack    <= '0;
      rom_en <= grant_found;
      if (grant_found) begin
        ack[grant_id] <= 1'b1;
        rom_addr      <= grant_addr;
        cur_id        <= grant_id;
        rr_ptr        <= next_ptr;
      end
    end
  end

  // Shift the read tag along with the ROM so the returning word knows its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        pipe_id[s] <= '0;
      end
    end else begin
      pipe_valid[0] <= rom_en;
      pipe_id[0]    <= cur_id;
      for (int s = 1; s < ROM_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_id[s]    <= pipe_id[s-1];
      end
    end
  end

  assign ret_valid = pipe_valid[ROM_LAT-1];
  assign ret_id    = pipe_id[ROM_LAT-1];

  // Steer returning data into the owner's holding register; disabled voices are cleared and drop late data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples      <= '0;
      sample_valid <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (!enables[i]) begin
          samples[i*DATA_W +: DATA_W] <= '0;
          sample_valid[i]             <= 1'b0;
        end else if (ret_valid && (ret_id == ID_W'(i))) begin
          samples[i*DATA_W +: DATA_W] <= rom_data;
          sample_valid[i]             <= 1'b1;
        end else begin
          sample_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = rom_en | (|pipe_valid);

endmodule

// File: tb/tb_wave_rom_scheduler.sv
// tb/tb_wave_rom_scheduler.sv - randomized and directed bench for wave_rom_scheduler against a queue-based model
module tb_wave_rom_scheduler;

  localparam int V   = 3;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [V-1:0]    enables;
  logic [V-1:0]    req;
  logic [V*AW-1:0] req_addrs;
  logic [V-1:0]    ack;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data = '0;
  logic [V*DW-1:0] samples;
  logic [V-1:0]    sample_valid;
  logic            busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [V-1:0]  m_ack;
  logic [V-1:0]  m_sv;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_smp [V];
  int            m_ptr;
  int            cyc;
  int            q_v[$];
  int            q_ret[$];
  logic [AW-1:0] q_addr[$];
  bit            auto_drop;

  wave_rom_scheduler #(.VOICES(V), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enables(enables), .req(req), .req_addrs(req_addrs),
    .ack(ack), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .samples(samples), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  // Synchronous ROM, one cycle of latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_f(rom_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [V*DW-1:0] m_packed();
    logic [V*DW-1:0] r;
    for (int v = 0; v < V; v++) r[v*DW +: DW] = m_smp[v];
    return r;
  endfunction

  task automatic set_addr(input int v, input logic [AW-1:0] a);
    req_addrs[v*AW +: AW] = a;
  endtask

  task automatic model_reset();
    q_v.delete(); q_ret.delete(); q_addr.delete();
    m_ack = '0; m_sv = '0; m_en = 1'b0; m_addr = '0; m_ptr = 0;
    for (int v = 0; v < V; v++) m_smp[v] = '0;
  endtask

  // One clock: model the cycle from the current inputs, then advance and observe at edge+1
  task automatic step();
    logic [V-1:0]  old_ack, n_sv, elig;
    logic [DW-1:0] n_smp [V];
    logic [AW-1:0] w_addr;
    int w, c;
    old_ack = m_ack; n_sv = '0; w = -1; w_addr = '0;
    for (int v = 0; v < V; v++) n_smp[v] = m_smp[v];
    for (int k = q_v.size() - 1; k >= 0; k--) begin
      if (q_ret[k] == cyc) begin
        if (enables[q_v[k]]) begin
          n_smp[q_v[k]] = rom_f(q_addr[k]);
          n_sv[q_v[k]]  = 1'b1;
        end
        q_v.delete(k); q_ret.delete(k); q_addr.delete(k);
      end
    end
    for (int v = 0; v < V; v++) if (!enables[v]) n_smp[v] = '0;
    elig = req & enables & ~m_ack;
    for (int j = 0; j < V; j++) begin
      c = (m_ptr + j) % V;
      if (w < 0 && elig[c]) w = c;
    end
    if (w >= 0) w_addr = req_addrs[w*AW +: AW];
    @(posedge clk); #1;
    for (int v = 0; v < V; v++) m_smp[v] = n_smp[v];
    m_sv = n_sv; m_ack = '0;
    if (w >= 0) begin
      m_ack[w] = 1'b1; m_en = 1'b1; m_addr = w_addr;
      q_v.push_back(w); q_ret.push_back(cyc + 1 + LAT); q_addr.push_back(w_addr);
      m_ptr = (w + 1) % V;
    end else begin
      m_en = 1'b0;
    end
    cyc++;
    if (auto_drop) req = req & ~old_ack;
  endtask

  task automatic apply_reset();
    req = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enables = '0; req = '0; req_addrs = '0; auto_drop = 0; cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack, rom_en, rom_addr, samples, sample_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b en=%b addr=%h smp=%h sv=%b busy=%b, expected all zero",
               ack, rom_en, rom_addr, samples, sample_valid, busy);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if ({ack, rom_en, sample_valid, busy, samples} !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got ack=%b en=%b sv=%b busy=%b smp=%h, expected all zero",
                 c, ack, rom_en, sample_valid, busy, samples);
      end
    end
  endtask

  task automatic test_single();
    enables = 3'b111; req_addrs = '0; set_addr(1, 12'h0A5); req = 3'b010; auto_drop = 1;
    step();
    checks++;
    if ({ack, rom_en, rom_addr} !== {3'b010, 1'b1, 12'h0A5}) begin
      errors++;
      $display("FAIL single_grant: got ack=%b en=%b addr=%h, expected ack=010 en=1 addr=0a5", ack, rom_en, rom_addr);
    end
    step();
    checks++;
    if ({ack, rom_en, busy} !== {3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_cycle2: got ack=%b en=%b busy=%b, expected ack=000 en=0 busy=1", ack, rom_en, busy);
    end
    step();
    checks++;
    if ({sample_valid, samples[15:8]} !== {3'b010, 8'hA5}) begin
      errors++;
      $display("FAIL single_sample: got sv=%b smp1=%h, expected sv=010 smp1=a5", sample_valid, samples[15:8]);
    end
    step();
    checks++;
    if ({sample_valid, samples[15:8], busy} !== {3'b000, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL single_hold: got sv=%b smp1=%h busy=%b, expected sv=000 smp1=a5 busy=0", sample_valid, samples[15:8], busy);
    end
  endtask

  task automatic test_simultaneous();
    logic [V-1:0]  exp_ack, exp_sv;
    logic [DW-1:0] exp_d;
    apply_reset();
    enables = 3'b111;
    set_addr(0, 12'h010); set_addr(1, 12'h020); set_addr(2, 12'h030);
    req = 3'b111; auto_drop = 1;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_ack = (c <= 3) ? 3'(1 << (c - 1)) : 3'b000;
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL simul_ack_c%0d: got %b expected %b", c, ack, exp_ack);
      end
      if (c <= 3) begin
        checks++;
        if (rom_addr !== 12'(16 * c)) begin
          errors++;
          $display("FAIL simul_addr_c%0d: got %h expected %h", c, rom_addr, 12'(16 * c));
        end
      end
      exp_sv = (c >= 3 && c <= 5) ? 3'(1 << (c - 3)) : 3'b000;
      checks++;
      if (sample_valid !== exp_sv) begin
        errors++;
        $display("FAIL simul_sv_c%0d: got %b expected %b", c, sample_valid, exp_sv);
      end
      if (c >= 3 && c <= 5) begin
        exp_d = 8'(16 * (c - 2));
        checks++;
        if (samples[(c-3)*DW +: DW] !== exp_d) begin
          errors++;
          $display("FAIL simul_data_c%0d: got %h expected %h", c, samples[(c-3)*DW +: DW], exp_d);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [V-1:0] exp_ack;
    set_addr(0, 12'h111); set_addr(2, 12'h1E2);
    req = 3'b101; auto_drop = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_ack = (c % 2 == 1) ? 3'b001 : 3'b100;
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL fair_c%0d: got ack=%b expected %b", c, ack, exp_ack);
      end
    end
    req = '0;
    repeat (4) step();
  endtask

  task automatic test_disable();
    set_addr(2, 12'h0C7); enables = 3'b111; req = 3'b100; auto_drop = 0;
    step();
    checks++;
    if ({ack, rom_addr} !== {3'b100, 12'h0C7}) begin
      errors++;
      $display("FAIL dis_grant: got ack=%b addr=%h expected ack=100 addr=0c7", ack, rom_addr);
    end
    step();
    enables = 3'b011;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (sample_valid[2] !== 1'b0 || ack[2] !== 1'b0) begin
        errors++;
        $display("FAIL dis_quiet_%0d: got sv2=%b ack2=%b expected 0 0", i, sample_valid[2], ack[2]);
      end
      if (i == 0) begin
        checks++;
        if (samples[23:16] !== 8'h00) begin
          errors++;
          $display("FAIL dis_clear: got smp2=%h expected 00", samples[23:16]);
        end
      end
    end
    enables = 3'b111; auto_drop = 1;
    step();
    checks++;
    if ({ack, rom_addr} !== {3'b100, 12'h0C7}) begin
      errors++;
      $display("FAIL reen_grant: got ack=%b addr=%h expected ack=100 addr=0c7", ack, rom_addr);
    end
    step();
    step();
    checks++;
    if ({sample_valid, samples[23:16]} !== {3'b100, 8'hC7}) begin
      errors++;
      $display("FAIL reen_sample: got sv=%b smp2=%h expected sv=100 smp2=c7", sample_valid, samples[23:16]);
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    enables = 3'b111; set_addr(0, 12'h05A); set_addr(1, 12'h0B4);
    req = 3'b011; auto_drop = 1;
    step();
    step();
    checks++;
    if ({ack, busy} !== {3'b010, 1'b1}) begin
      errors++;
      $display("FAIL mid_inflight: got ack=%b busy=%b expected ack=010 busy=1", ack, busy);
    end
    rst_n = 1'b0; req = '0;
    #1;
    checks++;
    if ({ack, rom_en, rom_addr, samples, sample_valid, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_zero: got ack=%b en=%b addr=%h smp=%h sv=%b busy=%b expected all zero",
               ack, rom_en, rom_addr, samples, sample_valid, busy);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if ({sample_valid, samples, rom_en, busy} !== '0) begin
        errors++;
        $display("FAIL mid_after_c%0d: got sv=%b smp=%h en=%b busy=%b expected all zero",
                 c, sample_valid, samples, rom_en, busy);
      end
    end
  endtask

  task automatic test_random();
    auto_drop = 1; enables = 3'b111;
    for (int c = 0; c < 400; c++) begin
      for (int v = 0; v < V; v++) begin
        if ($urandom_range(15) == 0) enables[v] = ~enables[v];
        if (!req[v] && $urandom_range(2) == 0) begin
          req[v] = 1'b1;
          set_addr(v, AW'($urandom));
        end
      end
      step();
      checks++;
      if (ack !== m_ack) begin
        errors++; $display("FAIL rnd_ack c%0d: got %b expected %b", cyc, ack, m_ack);
      end
      checks++;
      if (rom_en !== m_en) begin
        errors++; $display("FAIL rnd_rom_en c%0d: got %b expected %b", cyc, rom_en, m_en);
      end
      checks++;
      if (rom_addr !== m_addr) begin
        errors++; $display("FAIL rnd_rom_addr c%0d: got %h expected %h", cyc, rom_addr, m_addr);
      end
      checks++;
      if (sample_valid !== m_sv) begin
        errors++; $display("FAIL rnd_sv c%0d: got %b expected %b", cyc, sample_valid, m_sv);
      end
      checks++;
      if (samples !== m_packed()) begin
        errors++; $display("FAIL rnd_samples c%0d: got %h expected %h", cyc, samples, m_packed());
      end
      checks++;
      if (busy !== (q_v.size() != 0)) begin
        errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", cyc, busy, (q_v.size() != 0));
      end
    end
    req = '0;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
